// File: rtl/uart_transmitter.sv
// UART 8N1 transmitter: byte FIFO on a valid/ready input, LSB-first serialiser on TxD.
// Frames run back-to-back while the FIFO holds data.
//
// state   | meaning
// S_IDLE  | line high, waiting for a queued byte
// S_START | start bit (low) on the line
// S_DATA  | data bits, shreg[0] on the line
// S_STOP  | stop bit (high); may chain directly into the next frame
module uart_transmitter #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  TxD,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int BIT_DIV = CLK_FREQ / BAUD;
  localparam int CNT_W   = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
  localparam int DEPTH   = 1 << DEPTH_LOG2;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BIT_DIV - 1);
  localparam logic [DEPTH_LOG2:0] FULL     = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [CNT_W-1:0]        baud_q, baud_d;
  logic [2:0]              bit_idx_q, bit_idx_d;
  logic [7:0]              shreg_q, shreg_d;
  logic                    txd_q, txd_d;

  logic push;
  logic pop;
  logic bit_end;
  logic fifo_empty;

  assign fifo_empty = (count_q == '0);
  assign tx_ready   = (count_q != FULL);
  assign push       = tx_valid && tx_ready;
  assign bit_end    = (baud_q == CNT_LAST);

  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;
  assign TxD        = txd_q;

  // FIFO storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          shreg_d   = mem_q[rd_ptr_q];
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d    = '0;
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so frames stay gapless.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shreg_d   = mem_q[rd_ptr_q];
            bit_idx_d = '0;
            state_d   = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Line level is registered from the current state, so it trails the FSM by one cycle uniformly.
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      S_IDLE:  txd_d = 1'b1;
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shreg_q[0];
      S_STOP:  txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      txd_q     <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed + randomized bench for uart_transmitter: a fast instance (BIT_DIV=16) decoded by a
// line-level receiver model, and a default-parameter instance timed edge by edge.
module tb_uart_transmitter;

  localparam int BD   = 16;
  localparam int BD_D = 100_000_000 / 9600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rst_d;
  logic [7:0] tx_data, tx_data_d;
  logic       tx_valid, tx_valid_d;
  logic       tx_ready, tx_ready_d;
  logic       txd, txd_d;
  logic       busy, busy_d;
  logic [3:0] fifo_count, fifo_count_d;

  uart_transmitter #(.CLK_FREQ(16), .BAUD(1), .DEPTH_LOG2(3)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .TxD(txd), .busy(busy), .fifo_count(fifo_count)
  );

  uart_transmitter dut_dflt (
    .clk(clk), .rst(rst_d), .tx_data(tx_data_d), .tx_valid(tx_valid_d), .tx_ready(tx_ready_d),
    .TxD(txd_d), .busy(busy_d), .fifo_count(fifo_count_d)
  );

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: bytes expected on the line, in order.
  logic [7:0] exp_q[$];

  // Line receiver model: frame bits sampled at bit centres, start cycle of each frame.
  logic [9:0] rx_frame_q[$];
  int         rx_start_q[$];
  int         mon_pos = -1;
  int         mon_t   = 0;
  logic [9:0] mon_bits = '0;
  logic       mon_prev = 1'b1;

  always @(posedge clk) begin
    #1;
    if (rst !== 1'b1) begin
      mon_pos = -1;
    end else if (mon_pos < 0) begin
      if (mon_prev === 1'b1 && txd === 1'b0) begin
        mon_pos = 0;
        mon_t   = cyc;
      end
    end else begin
      mon_pos++;
    end
    if (mon_pos >= 0 && (mon_pos % BD) == BD / 2) mon_bits[mon_pos / BD] = txd;
    if (mon_pos == 9 * BD + BD / 2) begin
      rx_frame_q.push_back(mon_bits);
      rx_start_q.push_back(mon_t);
      mon_pos = -1;
    end
    mon_prev = txd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecs++;
    assert (obs === expv)
    else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_frame_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, rx_frame_q.size(), n);
  endtask

  task automatic cmp_frames(input string tag, input int n);
    logic [7:0] b;
    int         s;
    for (int i = 0; i < n; i++) begin
      if (rx_frame_q.size() == 0 || exp_q.size() == 0) break;
      b = exp_q.pop_front();
      s = rx_start_q.pop_front();
      chk(tag, rx_frame_q.pop_front(), {22'd0, 1'b1, b, 1'b0});
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 2000) begin
      tick();
      k++;
    end
    chk(tag, busy, 0);
    repeat (3) tick();
  endtask

  task automatic push1(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    exp_q.push_back(b);
    tick();
    tx_valid = 1'b0;
  endtask

  int         acc, s1, s2, mcount, n, k, t0;
  logic       exp_acc, quiet;
  logic [7:0] bx, by, bz;
  logic [9:0] fd;
  int         tr_obs[$];
  int         tr_exp[$];
  logic       prev_d;

  initial begin
    rst = 1'b1; rst_d = 1'b1;
    tx_data = '0; tx_valid = 1'b0; tx_data_d = '0; tx_valid_d = 1'b0;
    #2;
    rst = 1'b0; rst_d = 1'b0;
    repeat (3) tick();
    chk("rst_txd", txd, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_count", fifo_count, 0);
    rst = 1'b1; rst_d = 1'b1;
    repeat (2) tick();

    fork
      begin
        // Single byte 0x55: latency, pop timing, framing, busy release.
        tx_data = 8'h55; tx_valid = 1'b1; exp_q.push_back(8'h55);
        tick();
        acc = cyc; tx_valid = 1'b0;
        chk("t1_count_push", fifo_count, 1);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_count_pop", fifo_count, 0);
        chk("t1_txd_n1", txd, 1);
        tick();
        chk("t1_start_bit", txd, 0);
        wait_rx(1, 400, "t1_rx_timeout");
        if (rx_start_q.size() > 0) chk("t1_latency", rx_start_q[0] - acc, 2);
        cmp_frames("t1_frame", 1);
        k = 0;
        while (busy === 1'b1 && k < 100) begin tick(); k++; end
        chk("t1_busy_drop", cyc - acc, 1 + 10 * BD);
        wait_idle("t1_idle");

        // Back-to-back 0x00, 0xFF.
        tx_data = 8'h00; tx_valid = 1'b1; exp_q.push_back(8'h00);
        tick();
        acc = cyc;
        chk("t2_count_first", fifo_count, 1);
        tx_data = 8'hFF; exp_q.push_back(8'hFF);
        tick();
        tx_valid = 1'b0;
        chk("t2_count_pushpop", fifo_count, 1);
        wait_until(acc + 10 * BD);
        chk("t2_count_before_pop2", fifo_count, 1);
        tick();
        chk("t2_count_after_pop2", fifo_count, 0);
        wait_rx(2, 400, "t2_rx_timeout");
        if (rx_start_q.size() > 1) chk("t2_gap", rx_start_q[1] - rx_start_q[0], 10 * BD);
        cmp_frames("t2_frame", 2);
        wait_idle("t2_idle");

        // Overflow: valid held for 10 cycles, 0xA0..0xA9.
        mcount = 0;
        for (int i = 0; i < 10; i++) begin
          tx_data  = 8'hA0 + i[7:0];
          tx_valid = 1'b1;
          exp_acc  = (mcount != 8);
          chk("t3_ready", tx_ready, exp_acc);
          if (exp_acc) exp_q.push_back(tx_data);
          tick();
          mcount = mcount + (exp_acc ? 1 : 0) - ((i == 1) ? 1 : 0);
        end
        tx_valid = 1'b0;
        chk("t3_count_full", fifo_count, mcount);
        n = exp_q.size();
        wait_rx(n, n * 10 * BD + 200, "t3_rx_timeout");
        cmp_frames("t3_frame", n);
        wait_idle("t3_idle");
        repeat (200) tick();
        chk("t3_no_extra", rx_frame_q.size(), 0);

        // Random bytes with random gaps.
        n = $urandom_range(3, 6);
        for (int i = 0; i < n; i++) begin
          push1(8'($urandom));
          repeat ($urandom_range(0, 40)) tick();
        end
        wait_rx(n, n * 10 * BD + 400, "t4_rx_timeout");
        cmp_frames("t4_frame", n);
        wait_idle("t4_idle");

        // Push on the exact STOP->START pop cycle.
        bx = 8'($urandom); by = 8'($urandom); bz = 8'($urandom);
        tx_data = bx; tx_valid = 1'b1; exp_q.push_back(bx);
        tick();
        acc = cyc;
        tx_data = by; exp_q.push_back(by);
        tick();
        tx_valid = 1'b0;
        wait_until(acc + 10 * BD);
        chk("t5_count_before", fifo_count, 1);
        tx_data = bz; tx_valid = 1'b1; exp_q.push_back(bz);
        tick();
        tx_valid = 1'b0;
        chk("t5_count_pushpop", fifo_count, 1);
        wait_rx(3, 3 * 10 * BD + 200, "t5_rx_timeout");
        cmp_frames("t5_frame", 3);
        wait_idle("t5_idle");

        // Reset during data bit 3 of 0x3C with two bytes queued.
        tx_data = 8'h3C; tx_valid = 1'b1;
        tick();
        acc = cyc;
        tx_data = 8'($urandom);
        tick();
        tx_data = 8'($urandom);
        tick();
        tx_valid = 1'b0;
        chk("t6_count_queued", fifo_count, 2);
        wait_until(acc + 2 + 4 * BD + 6);
        rst = 1'b0;
        #1;
        chk("t6_rst_txd", txd, 1);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ready", tx_ready, 1);
        repeat (3) tick();
        rst = 1'b1;
        quiet = 1'b1;
        repeat (300) begin
          tick();
          if (txd !== 1'b1) quiet = 1'b0;
        end
        chk("t6_line_quiet", quiet, 1);
        chk("t6_no_frame", rx_frame_q.size(), 0);
        push1(8'h81);
        wait_rx(1, 400, "t6_rx_timeout");
        cmp_frames("t6_frame", 1);
      end

      begin
        // Default parameters: 0x4B, bit period measured on the first five bits.
        fd = {1'b1, 8'h4B, 1'b0};
        tx_data_d = 8'h4B; tx_valid_d = 1'b1;
        tick();
        acc = cyc; tx_valid_d = 1'b0;
        k = 0;
        while (txd_d !== 1'b0 && k < 10) begin tick(); k++; end
        t0 = cyc;
        chk("dflt_latency", t0 - acc, 2);
        for (int b = 1; b < 5; b++) if (fd[b] != fd[b-1]) tr_exp.push_back(b * BD_D);
        prev_d = txd_d;
        for (int p = 1; p < 5 * BD_D; p++) begin
          tick();
          if (txd_d !== prev_d) tr_obs.push_back(p);
          prev_d = txd_d;
          if (p % BD_D == BD_D / 2) chk("dflt_bit", txd_d, fd[p / BD_D]);
        end
        chk("dflt_edges", tr_obs.size(), tr_exp.size());
        for (int i = 0; i < tr_exp.size() && i < tr_obs.size(); i++)
          chk("dflt_edge_time", tr_obs[i], tr_exp[i]);
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
